// File: rtl/conv_operand_loader_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : conv_loader_pkg
// Purpose  : Shared constants and the FSM state type for conv_operand_loader.
//            Default operand width and matrix sizes, derived beat counts and
//            the counter width for one frame of staged operands.
// Revision : 1.0 - initial release
// ============================================================================
package conv_loader_pkg;

    localparam int DATA_W  = 8;
    localparam int A_DIM   = 4;
    localparam int B_DIM   = 3;
    localparam int N_A     = A_DIM * A_DIM;
    localparam int N_B     = B_DIM * B_DIM;
    localparam int N_BEATS = N_A + N_B;
    localparam int CNT_W   = $clog2(N_BEATS + 1);

    // FILL: accepting beats, PEND: frame staged and waiting for top,
    // FIRE: single cycle in which the committed operands and run are new.
    typedef enum logic [1:0] {
        FILL = 2'd0,
        PEND = 2'd1,
        FIRE = 2'd2
    } state_t;

endpackage : conv_loader_pkg
`default_nettype wire

// File: rtl/conv_operand_loader_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : conv_operand_loader_if
// Purpose  : Serial operand byte stream with valid/ready handshake.
// Signals  : in_valid  - beat valid (master -> loader)
//            in_data   - beat payload (master -> loader)
//            in_ready  - loader accepts the beat this cycle (loader -> master)
// Modports : master (stream source), slave (loader)
// Revision : 1.0 - initial release
// ============================================================================
interface conv_operand_loader_if #(
    parameter int DATA_W = conv_loader_pkg::DATA_W
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;

    modport master (output in_valid, output in_data, input  in_ready);
    modport slave  (input  in_valid, input  in_data, output in_ready);

endinterface : conv_operand_loader_if
`default_nettype wire

// File: rtl/conv_operand_loader_stage_buf.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : operand_stage_buf
// Purpose  : DEPTH x DATA_W staging buffer. One indexed write per cycle, the
//            whole contents are visible as a flat vector (entry 0 in the LSBs).
// Ports    : clk     - clock, rising edge
//            reset   - asynchronous, active-low; clears every entry
//            wr_en   - write strobe
//            wr_idx  - entry to write (caller keeps it below DEPTH)
//            wr_data - data written
//            rd_flat - flat read-out of all entries
// Revision : 1.0 - initial release
// ============================================================================
module operand_stage_buf #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 25,
    parameter int IDX_W  = 5
) (
    input  wire logic                    clk,
    input  wire logic                    reset,
    input  wire logic                    wr_en,
    input  wire logic [IDX_W-1:0]        wr_idx,
    input  wire logic [DATA_W-1:0]       wr_data,
    output logic      [DEPTH*DATA_W-1:0] rd_flat
);

    logic [DEPTH-1:0][DATA_W-1:0] mem;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem <= '0;
        end else if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_flat = mem;

endmodule : operand_stage_buf
`default_nettype wire

// File: rtl/conv_operand_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : conv_operand_loader
// Purpose  : Collects image and filter operands from a serial byte stream
//            into a staging buffer, then commits them to stable parallel
//            outputs and pulses run for one cycle. The next frame can be
//            staged while the downstream top is still computing.
// Ports    : clk     - clock, rising edge
//            reset   - asynchronous, active-low; clears all state
//            stream  - operand byte stream (slave side)
//            done    - 1-cycle pulse from top: result finished
//            a_flat  - committed image, a11 in the LSBs
//            b_flat  - committed filter, b11 in the LSBs
//            run     - 1-cycle start pulse to top
//            busy    - top computing (run issued, done not yet seen)
//            err     - sticky checksum error
// Config   : CONV_LOADER_CHECKSUM_EN - frames carry a trailing checksum beat
//            (sum of all operand beats mod 2^DATA_W); a mismatching frame is
//            dropped and err is set. Undefined: no checksum, err tied low.
// Revision : 1.0 - initial release
// ============================================================================
module conv_operand_loader #(
    parameter int DATA_W = conv_loader_pkg::DATA_W,
    parameter int A_DIM  = conv_loader_pkg::A_DIM,
    parameter int B_DIM  = conv_loader_pkg::B_DIM
) (
    input  wire logic                          clk,
    input  wire logic                          reset,
    conv_operand_loader_if.slave               stream,
    input  wire logic                          done,
    output logic [A_DIM*A_DIM*DATA_W-1:0]      a_flat,
    output logic [B_DIM*B_DIM*DATA_W-1:0]      b_flat,
    output logic                               run,
    output logic                               busy,
    output logic                               err
);

    import conv_loader_pkg::*;

    localparam int N_IMG   = A_DIM * A_DIM;
    localparam int N_FLT   = B_DIM * B_DIM;
    localparam int N_STAGE = N_IMG + N_FLT;
`ifdef CONV_LOADER_CHECKSUM_EN
    localparam int N_FRAME = N_STAGE + 1;
`else
    localparam int N_FRAME = N_STAGE;
`endif
    localparam int          CW   = $clog2(N_FRAME);
    localparam logic [CW-1:0] LAST = CW'(N_FRAME - 1);

    state_t                    state;
    state_t                    state_nxt;
    logic [CW-1:0]             cnt;
    logic                      accept;
    logic                      last_beat;
    logic                      stage_we;
    logic                      fire_go;
    logic                      frame_ok;
    logic [N_STAGE*DATA_W-1:0] stage_flat;

    // Ready depends on state only, so the handshake has no combinational
    // path back from in_valid.
    assign stream.in_ready = (state == FILL);
    assign accept          = stream.in_valid & stream.in_ready;
    assign last_beat       = accept & (cnt == LAST);
    // The checksum beat (when present) is not stored.
    assign stage_we        = accept & (cnt < CW'(N_STAGE));
    // A done arriving while pending frees top in the same cycle.
    assign fire_go         = (state == PEND) & (~busy | done);

    operand_stage_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (N_STAGE),
        .IDX_W  (CW)
    ) u_stage (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (stage_we),
        .wr_idx  (cnt),
        .wr_data (stream.in_data),
        .rd_flat (stage_flat)
    );

`ifdef CONV_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] csum;

    // Running sum of the operand beats; restarts with every frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csum <= '0;
        end else if (accept) begin
            csum <= last_beat ? '0 : csum + stream.in_data;
        end
    end

    assign frame_ok = (csum == stream.in_data);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err <= 1'b0;
        end else if (last_beat && !frame_ok) begin
            err <= 1'b1;
        end
    end
`else
    assign frame_ok = 1'b1;
    assign err      = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FILL: begin
                if (last_beat) begin
                    state_nxt = frame_ok ? PEND : FILL;
                end
            end
            PEND: begin
                if (fire_go) begin
                    state_nxt = FIRE;
                end
            end
            FIRE:    state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

    // Commit registers: operands move only on entry to FIRE. A done seen
    // during FIRE belongs to the previous computation and is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_flat <= '0;
            b_flat <= '0;
            run    <= 1'b0;
            busy   <= 1'b0;
        end else begin
            run <= fire_go;
            if (fire_go) begin
                a_flat <= stage_flat[N_IMG*DATA_W-1:0];
                b_flat <= stage_flat[N_STAGE*DATA_W-1:N_IMG*DATA_W];
                busy   <= 1'b1;
            end else if (done && (state != FIRE)) begin
                busy   <= 1'b0;
            end
        end
    end

endmodule : conv_operand_loader
`default_nettype wire

// File: tb/tb_conv_operand_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_conv_operand_loader
// Purpose  : Self-checking bench for conv_operand_loader. Frames are built
//            as byte arrays; expected committed operands are packed from the
//            array and run/busy timing follows the handshake rules.
// Config   : CONV_LOADER_CHECKSUM_EN adds a checksum beat to every frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_operand_loader;

    import conv_loader_pkg::*;

`ifdef CONV_LOADER_CHECKSUM_EN
    localparam int NB = N_BEATS + 1;
`else
    localparam int NB = N_BEATS;
`endif

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    done;
    logic [N_A*DATA_W-1:0]   a_flat;
    logic [N_B*DATA_W-1:0]   b_flat;
    logic                    run;
    logic                    busy;
    logic                    err;

    conv_operand_loader_if #(.DATA_W(DATA_W)) sif ();

    conv_operand_loader dut (
        .clk    (clk),
        .reset  (reset),
        .stream (sif),
        .done   (done),
        .a_flat (a_flat),
        .b_flat (b_flat),
        .run    (run),
        .busy   (busy),
        .err    (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int run_cnt = 0;
    int acc_cnt = 0;

    always @(posedge clk) begin
        if (run) run_cnt++;
        if (sif.in_valid && sif.in_ready) acc_cnt++;
    end

    logic [7:0] c1 [N_BEATS] = '{8'd3, 8'd1, 8'd6, 8'd5, 8'd7, 8'd5, 8'd2, 8'd7,
                                  8'd7, 8'd10, 8'd8, 8'd9, 8'd1, 8'd3, 8'd2, 8'd10,
                                  8'd3, 8'd1, 8'd4, 8'd0, 8'd5, 8'd1, 8'd0, 8'd1, 8'd5};
    logic [7:0] frm [NB];
    logic [N_A*DATA_W-1:0] prev_a;
    logic [N_B*DATA_W-1:0] prev_b;
    bit mdl_busy;

    function automatic logic [N_A*DATA_W-1:0] exp_a();
        logic [N_A*DATA_W-1:0] r;
        for (int i = 0; i < N_A; i++) r[i*DATA_W +: DATA_W] = frm[i];
        return r;
    endfunction

    function automatic logic [N_B*DATA_W-1:0] exp_b();
        logic [N_B*DATA_W-1:0] r;
        for (int i = 0; i < N_B; i++) r[i*DATA_W +: DATA_W] = frm[N_A + i];
        return r;
    endfunction

    task automatic make_frame(input int kind);
        int s;
        for (int i = 0; i < N_BEATS; i++)
            frm[i] = (kind == 0) ? c1[i] : 8'($urandom_range(0, 255));
`ifdef CONV_LOADER_CHECKSUM_EN
        s = 0;
        for (int i = 0; i < N_BEATS; i++) s += int'(frm[i]);
        frm[N_BEATS] = 8'(s % 256);
`else
        s = 0;
`endif
    endtask

    // gap: 0 none, 1 alternate idle cycles, 2 random idle cycles.
    // cut: stop after this many beats (-1 = whole frame).
    task automatic send_frame(input int gap, input int cut);
        int t;
        for (int i = 0; i < NB; i++) begin
            if (cut >= 0 && i >= cut) break;
            if ((gap == 1 && i > 0) || (gap == 2 && $urandom_range(0, 2) == 0)) begin
                sif.in_valid = 1'b0;
                sif.in_data  = 8'($urandom_range(0, 255));
                @(posedge clk); #1;
            end
            sif.in_valid = 1'b1;
            sif.in_data  = frm[i];
            t = 0;
            while (!sif.in_ready && t < 200) begin
                @(posedge clk); #1;
                t++;
            end
            if (!sif.in_ready) begin
                checks++; errors++;
                $display("FAIL ready_timeout beat=%0d in_ready=%0b required=1", i, sif.in_ready);
                sif.in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        sif.in_valid = 1'b0;
    endtask

    task automatic clear_busy();
        done = 1'b1;
        @(posedge clk); #1;
        done = 1'b0;
        mdl_busy = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; done = 1'b0; sif.in_valid = 1'b0; sif.in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (a_flat !== '0) begin errors++; $display("FAIL reset_a got=%h exp=0", a_flat); end
        checks++; if (b_flat !== '0) begin errors++; $display("FAIL reset_b got=%h exp=0", b_flat); end
        checks++; if ({run, busy, err} !== 3'b000) begin errors++; $display("FAIL reset_flags got run/busy/err=%b exp=000", {run, busy, err}); end
        checks++; if (sif.in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", sif.in_ready); end
        reset = 1'b1;
        @(posedge clk); #1;
        mdl_busy = 1'b0;
    endtask

    task automatic test_basic();
        int r0;
        make_frame(0);
        r0 = run_cnt;
        send_frame(0, -1);
        checks++; if (run !== 1'b0) begin errors++; $display("FAIL basic_run_early got=%b exp=0", run); end
        checks++; if (sif.in_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_pend got=%b exp=0", sif.in_ready); end
        @(posedge clk); #1;
        checks++; if (run !== 1'b1) begin errors++; $display("FAIL basic_run got=%b exp=1", run); end
        checks++; if (a_flat[7:0] !== 8'd3 || a_flat[127:120] !== 8'd10) begin errors++; $display("FAIL basic_a_ends got=%0d/%0d exp=3/10", a_flat[7:0], a_flat[127:120]); end
        checks++; if (b_flat[7:0] !== 8'd3 || b_flat[71:64] !== 8'd5) begin errors++; $display("FAIL basic_b_ends got=%0d/%0d exp=3/5", b_flat[7:0], b_flat[71:64]); end
        checks++; if (a_flat !== exp_a() || b_flat !== exp_b()) begin errors++; $display("FAIL basic_ops got=%h/%h exp=%h/%h", a_flat, b_flat, exp_a(), exp_b()); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b exp=1", busy); end
        @(posedge clk); #1;
        checks++; if (run !== 1'b0) begin errors++; $display("FAIL basic_run_len got=%b exp=0", run); end
        checks++; if (run_cnt - r0 !== 1) begin errors++; $display("FAIL basic_run_count got=%0d exp=1", run_cnt - r0); end
        prev_a = exp_a(); prev_b = exp_b(); mdl_busy = 1'b1;
    endtask

    task automatic test_back_to_back();
        int r0, a0;
        make_frame(1);
        r0 = run_cnt;
        send_frame(0, -1);
        checks++; if (sif.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready got=%b exp=0", sif.in_ready); end
        a0 = acc_cnt;
        for (int k = 0; k < 4; k++) begin
            sif.in_valid = 1'b1;
            sif.in_data  = 8'($urandom_range(0, 255));
            @(posedge clk); #1;
        end
        sif.in_valid = 1'b0;
        checks++; if (acc_cnt - a0 !== 0) begin errors++; $display("FAIL b2b_ignored_beats got=%0d exp=0", acc_cnt - a0); end
        checks++; if (a_flat !== prev_a || b_flat !== prev_b) begin errors++; $display("FAIL b2b_hold got=%h exp=%h", a_flat, prev_a); end
        checks++; if (run_cnt - r0 !== 0) begin errors++; $display("FAIL b2b_no_run got=%0d exp=0", run_cnt - r0); end
        done = 1'b1;
        @(posedge clk); #1;
        done = 1'b0;
        checks++; if (run !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL b2b_fire got run/busy=%b%b exp=11", run, busy); end
        checks++; if (a_flat !== exp_a() || b_flat !== exp_b()) begin errors++; $display("FAIL b2b_ops got=%h/%h exp=%h/%h", a_flat, b_flat, exp_a(), exp_b()); end
        @(posedge clk); #1;
        prev_a = exp_a(); prev_b = exp_b(); mdl_busy = 1'b1;
    endtask

    task automatic test_gaps();
        int a0;
        clear_busy();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL gaps_busy_clear got=%b exp=0", busy); end
        make_frame(0);
        a0 = acc_cnt;
        send_frame(1, -1);
        checks++; if (acc_cnt - a0 !== NB) begin errors++; $display("FAIL gaps_beats got=%0d exp=%0d", acc_cnt - a0, NB); end
        @(posedge clk); #1;
        checks++; if (run !== 1'b1 || a_flat !== exp_a() || b_flat !== exp_b()) begin errors++; $display("FAIL gaps_commit got run=%b a=%h exp run=1 a=%h", run, a_flat, exp_a()); end
        @(posedge clk); #1;
        prev_a = exp_a(); prev_b = exp_b(); mdl_busy = 1'b1;
    endtask

    task automatic test_reset_mid();
        int r0;
        clear_busy();
        make_frame(1);
        r0 = run_cnt;
        send_frame(0, 12);
        reset = 1'b0;
        #1;
        checks++; if (a_flat !== '0 || b_flat !== '0) begin errors++; $display("FAIL rstmid_zero got=%h/%h exp=0", a_flat, b_flat); end
        checks++; if (busy !== 1'b0 || run !== 1'b0) begin errors++; $display("FAIL rstmid_flags got run/busy=%b%b exp=00", run, busy); end
        repeat (2) @(posedge clk);
        #1; reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (run_cnt - r0 !== 0) begin errors++; $display("FAIL rstmid_no_run got=%0d exp=0", run_cnt - r0); end
        make_frame(1);
        send_frame(0, -1);
        @(posedge clk); #1;
        checks++; if (run !== 1'b1 || a_flat !== exp_a() || b_flat !== exp_b()) begin errors++; $display("FAIL rstmid_fresh got run=%b a=%h exp run=1 a=%h", run, a_flat, exp_a()); end
        @(posedge clk); #1;
        prev_a = exp_a(); prev_b = exp_b(); mdl_busy = 1'b1;
    endtask

    task automatic test_done_pend();
        int r0;
        make_frame(1);
        r0 = run_cnt;
        send_frame(0, NB - 1);
        sif.in_valid = 1'b1;
        sif.in_data  = frm[NB-1];
        done = 1'b1;
        @(posedge clk); #1;
        done = 1'b0;
        sif.in_valid = 1'b0;
        checks++; if (busy !== 1'b0 || run !== 1'b0) begin errors++; $display("FAIL donepend_enter got run/busy=%b%b exp=00", run, busy); end
        @(posedge clk); #1;
        checks++; if (run !== 1'b1 || busy !== 1'b1 || a_flat !== exp_a()) begin errors++; $display("FAIL donepend_fire got run/busy=%b%b a=%h exp 11 a=%h", run, busy, a_flat, exp_a()); end
        done = 1'b1;
        @(posedge clk); #1;
        done = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL done_in_fire_busy got=%b exp=1", busy); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (run_cnt - r0 !== 1) begin errors++; $display("FAIL donepend_runs got=%0d exp=1", run_cnt - r0); end
        prev_a = exp_a(); prev_b = exp_b(); mdl_busy = 1'b1;
    endtask

    task automatic test_random();
        int k;
        for (int f = 0; f < 8; f++) begin
            if (mdl_busy && $urandom_range(0, 1) == 1) clear_busy();
            make_frame(1);
            send_frame(2, -1);
            if (mdl_busy) begin
                k = $urandom_range(0, 3);
                for (int c = 0; c < k; c++) begin
                    checks++; if (run !== 1'b0 || a_flat !== prev_a) begin errors++; $display("FAIL rand_hold f=%0d got run=%b a=%h exp run=0 a=%h", f, run, a_flat, prev_a); end
                    @(posedge clk); #1;
                end
                done = 1'b1;
                @(posedge clk); #1;
                done = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
            checks++; if (run !== 1'b1 || a_flat !== exp_a() || b_flat !== exp_b()) begin errors++; $display("FAIL rand_commit f=%0d got run=%b a=%h b=%h exp a=%h b=%h", f, run, a_flat, b_flat, exp_a(), exp_b()); end
            prev_a = exp_a(); prev_b = exp_b(); mdl_busy = 1'b1;
            @(posedge clk); #1;
        end
    endtask

`ifdef CONV_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        int r0;
        clear_busy();
        make_frame(0);
        send_frame(0, -1);
        @(posedge clk); #1;
        checks++; if (run !== 1'b1 || a_flat !== exp_a() || err !== 1'b0) begin errors++; $display("FAIL csum_good got run=%b err=%b exp run=1 err=0", run, err); end
        prev_a = exp_a(); prev_b = exp_b();
        @(posedge clk); #1;
        clear_busy();
        make_frame(0);
        frm[N_BEATS] = frm[N_BEATS] + 8'd1;
        r0 = run_cnt;
        send_frame(0, -1);
        repeat (4) @(posedge clk);
        #1;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL csum_err got=%b exp=1", err); end
        checks++; if (run_cnt - r0 !== 0 || a_flat !== prev_a) begin errors++; $display("FAIL csum_drop got runs=%0d a=%h exp runs=0 a=%h", run_cnt - r0, a_flat, prev_a); end
        checks++; if (sif.in_ready !== 1'b1) begin errors++; $display("FAIL csum_back_fill got=%b exp=1", sif.in_ready); end
        make_frame(1);
        send_frame(0, -1);
        @(posedge clk); #1;
        checks++; if (run !== 1'b1 || a_flat !== exp_a() || b_flat !== exp_b() || err !== 1'b1) begin errors++; $display("FAIL csum_recover got run=%b err=%b a=%h exp run=1 err=1 a=%h", run, err, a_flat, exp_a()); end
        @(posedge clk); #1;
        mdl_busy = 1'b1;
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_gaps();
        test_reset_mid();
        test_done_pend();
        test_random();
`ifdef CONV_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_conv_operand_loader
`default_nettype wire
